// File: rtl/img_acc_pkg.sv
// Shared types for the image accelerator system-side drivers.
// Holds the processing value width, the accelerator mode encoding and the driver FSM states.
package img_acc_pkg;

    localparam int COLOR_SIZE = 8;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head word.
// DEPTH must be a power of two; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The head reads as zero when empty so a flushed FIFO presents no stale data.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/img_slv_driver.sv
// Drives one accelerator slave port: buffers upstream pixel words and streams
// one frame of a programmed length with mode and processing value held constant.
module img_slv_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = img_acc_pkg::COLOR_SIZE,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [1:0]            cfg_mode,
    input  logic [COLOR_SIZE-1:0] cfg_proc_val,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [1:0]            slv_mode,
    output logic [COLOR_SIZE-1:0] slv_proc_val,
    output logic [DATA_WIDTH-1:0] slv_data,
    output logic                  slv_data_valid,
    input  logic                  slv_rdy,
    output logic                  busy,
    output logic                  done
);

    import img_acc_pkg::*;

    state_t                state;
    state_t                state_nxt;
    mode_t                 mode_q;
    logic [COLOR_SIZE-1:0] proc_val_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  xfer;
    logic                  start_ok;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign xfer     = slv_data_valid && slv_rdy;
    assign start_ok = (state == ST_IDLE) && cfg_start;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (xfer),
        .head      (slv_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start) state_nxt = (cfg_len == '0) ? ST_DONE : ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer && remaining == LEN_WIDTH'(1)) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        slv_data_valid = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            ST_STREAM: begin
                slv_data_valid = !fifo_empty;
                busy           = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame configuration is captured only on an accepted start, so a start
    // request arriving mid-frame leaves mode, value and count untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_0;
            proc_val_q <= '0;
            remaining  <= '0;
        end else if (start_ok) begin
            mode_q     <= mode_t'(cfg_mode);
            proc_val_q <= cfg_proc_val;
            remaining  <= cfg_len;
        end else if (xfer) begin
            remaining  <= remaining - 1'b1;
        end
    end

    assign slv_mode     = mode_q;
    assign slv_proc_val = proc_val_q;

endmodule
